// File: rtl/sync_handshake_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | sync_handshake_tx_if : producer, far-side and status signals      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface sync_handshake_tx_if #(
  parameter int DATA_W = 32
);
  logic              in_vld;
  logic [DATA_W-1:0] in_data;
  logic              in_rdy;
  logic              tx_req;
  logic [DATA_W-1:0] tx_data;
  logic              ack_async;
  logic              busy;
  logic              err_timeout;
  logic              err_spur;
  logic              err_clr;

  modport master (
    input  in_vld, in_data, ack_async, err_clr,
    output in_rdy, tx_req, tx_data, busy, err_timeout, err_spur
  );

  modport slave (
    output in_vld, in_data, ack_async, err_clr,
    input  in_rdy, tx_req, tx_data, busy, err_timeout, err_spur
  );
endinterface
`default_nettype wire

// File: rtl/sync_handshake_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | sync_handshake_tx : transmit end of a four-phase req/ack crossing |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sync_handshake_tx #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   rclk,
  input  logic                   arst_l,
  sync_handshake_tx_if.master    bus
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] c_TO_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam bit               c_TO_EN   = (TIMEOUT_CYC > 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ_HI = 2'd1,
    S_ACK_LO = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_tx_req;
  logic [DATA_W-1:0]      r_tx_data;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_err_timeout;
  logic                   r_err_spur;
  logic [SYNC_STAGES-1:0] r_ack_sync;

  logic w_ack_sync;
  logic w_in_rdy;
  logic w_waiting;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.ack_async};
    end
  end

  assign w_ack_sync = r_ack_sync[SYNC_STAGES-1];
  assign w_in_rdy   = (r_state == S_IDLE) && !w_ack_sync;
  // Leaving ACK_LO this cycle means the handshake is done, so it no longer counts as waiting.
  assign w_waiting  = (r_state == S_REQ_HI) || ((r_state == S_ACK_LO) && w_ack_sync);

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_state       <= S_IDLE;
      r_tx_req      <= 1'b0;
      r_tx_data     <= '0;
      r_cnt         <= '0;
      r_err_timeout <= 1'b0;
      r_err_spur    <= 1'b0;
    end else begin
      if (bus.err_clr) begin
        r_err_timeout <= 1'b0;
        r_err_spur    <= 1'b0;
      end

      if ((r_state != S_IDLE) && (r_cnt != c_TO_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (c_TO_EN && w_waiting && (r_cnt == c_TO_LAST)) begin
        r_err_timeout <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_ack_sync) begin
            r_err_spur <= 1'b1;
          end else if (bus.in_vld) begin
            r_tx_data <= bus.in_data;
            r_tx_req  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_REQ_HI;
          end
        end
        S_REQ_HI: begin
          if (w_ack_sync) begin
            r_tx_req <= 1'b0;
            r_state  <= S_ACK_LO;
          end
        end
        S_ACK_LO: begin
          if (!w_ack_sync) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_tx_req <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_rdy      = w_in_rdy;
  assign bus.tx_req      = r_tx_req;
  assign bus.tx_data     = r_tx_data;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.err_timeout = r_err_timeout;
  assign bus.err_spur    = r_err_spur;

endmodule
`default_nettype wire

// File: tb/tb_sync_handshake_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sync_handshake_tx : directed and randomized checks of the      |
// | transmit end against a far-side receiver model. Rev 1.0          |
// +------------------------------------------------------------------+
module tb_sync_handshake_tx;
  localparam int DATA_W      = 32;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_CYC = 16;

  logic rclk   = 1'b0;
  logic arst_l = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sync_handshake_tx_if #(.DATA_W(DATA_W)) bus ();

  sync_handshake_tx #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .rclk   (rclk),
    .arst_l (arst_l),
    .bus    (bus)
  );

  always #5 rclk = ~rclk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Far-side receiver: waits for a request, latches the word, acks after d_ack
  // cycles, releases d_drop cycles after the request falls.
  task automatic far_handshake(input int d_ack, input int d_drop, output logic [DATA_W-1:0] seen);
    int n;
    bit hold_ok;
    hold_ok = 1'b1;
    n = 0;
    while (bus.tx_req !== 1'b1 && n < 40) begin tick(); n++; end
    check("far_req_rise", bus.tx_req, 1);
    seen = bus.tx_data;
    for (int i = 0; i < d_ack; i++) begin
      tick();
      if (bus.tx_data !== seen) hold_ok = 1'b0;
    end
    bus.ack_async = 1'b1;
    n = 0;
    while (bus.tx_req !== 1'b0 && n < 40) begin
      tick(); n++;
      if (bus.tx_data !== seen) hold_ok = 1'b0;
    end
    check("far_req_fall", bus.tx_req, 0);
    for (int i = 0; i < d_drop; i++) begin
      tick();
      if (bus.tx_data !== seen) hold_ok = 1'b0;
    end
    bus.ack_async = 1'b0;
    n = 0;
    while (bus.busy !== 1'b0 && n < 40) begin
      tick(); n++;
      if (bus.tx_data !== seen) hold_ok = 1'b0;
    end
    check("far_idle", bus.busy, 0);
    check("far_data_hold", hold_ok, 1);
  endtask

  // Producer streams n words while a randomized far side answers; the words
  // received on the far side must equal the words offered, in order.
  task automatic run_stream(input int n, input bit rnd_data, input bit rnd_gap, input int max_dly);
    logic [DATA_W-1:0] words[$];
    logic [DATA_W-1:0] rx_q[$];
    logic [DATA_W-1:0] cur;
    int  sent;
    int  far_dly;
    int  cyc;
    bit  acc;
    bit  hold_ok;
    sent = 0; far_dly = 0; cyc = 0; hold_ok = 1'b1; cur = '0;
    for (int i = 0; i < n; i++) words.push_back(rnd_data ? DATA_W'($urandom) : DATA_W'(i + 1));
    bus.in_vld  = 1'b1;
    bus.in_data = words[0];
    while ((sent < n || bus.busy || bus.ack_async) && cyc < 2000) begin
      acc = bus.in_vld && bus.in_rdy;
      tick(); cyc++;
      if (acc) begin cur = words[sent]; sent++; end
      if (bus.busy && bus.tx_data !== cur) hold_ok = 1'b0;
      if (acc || !bus.in_vld) begin
        if (sent < n && (!rnd_gap || $urandom_range(0, 1) == 0)) begin
          bus.in_vld  = 1'b1;
          bus.in_data = words[sent];
        end else begin
          bus.in_vld  = 1'b0;
          bus.in_data = DATA_W'($urandom);
        end
      end
      if (bus.tx_req && !bus.ack_async) begin
        if (far_dly == 0) begin
          rx_q.push_back(bus.tx_data);
          bus.ack_async = 1'b1;
          far_dly = $urandom_range(0, max_dly);
        end else far_dly--;
      end else if (!bus.tx_req && bus.ack_async) begin
        if (far_dly == 0) begin
          bus.ack_async = 1'b0;
          far_dly = $urandom_range(0, max_dly);
        end else far_dly--;
      end
    end
    bus.in_vld = 1'b0;
    check("stream_budget", (cyc < 2000), 1);
    check("stream_count", rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++) check("stream_word", rx_q[i], words[i]);
    check("stream_hold", hold_ok, 1);
    check("stream_no_timeout", bus.err_timeout, 0);
    check("stream_no_spur", bus.err_spur, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] seen;
    bus.in_vld    = 1'b0;
    bus.in_data   = '0;
    bus.ack_async = 1'b0;
    bus.err_clr   = 1'b0;

    ticks(2);
    check("rst_tx_req", bus.tx_req, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_rdy", bus.in_rdy, 1);
    check("rst_err_to", bus.err_timeout, 0);
    check("rst_err_spur", bus.err_spur, 0);
    arst_l = 1'b1;
    tick();

    // First word: request one cycle after acceptance
    bus.in_vld  = 1'b1;
    bus.in_data = 32'hA5A5_0001;
    tick();
    check("t1_tx_req", bus.tx_req, 1);
    check("t1_tx_data", bus.tx_data, 32'hA5A5_0001);
    check("t1_in_rdy", bus.in_rdy, 0);
    check("t1_busy", bus.busy, 1);
    bus.in_vld = 1'b0;

    // Ack timing through the two-flop synchronizer
    ticks(2);
    bus.ack_async = 1'b1;
    ticks(2);
    check("t2_req_hold", bus.tx_req, 1);
    tick();
    check("t2_req_fall", bus.tx_req, 0);
    check("t2_data_keep", bus.tx_data, 32'hA5A5_0001);
    ticks(2);
    bus.ack_async = 1'b0;
    bus.in_vld    = 1'b1;
    bus.in_data   = 32'h5A5A_0002;
    ticks(2);
    check("t2_rdy_low", bus.in_rdy, 0);
    check("t2_busy", bus.busy, 1);
    check("t2_data_held", bus.tx_data, 32'hA5A5_0001);
    tick();
    check("t2_rdy_high", bus.in_rdy, 1);
    check("t2_idle", bus.busy, 0);
    check("t2_data_idle", bus.tx_data, 32'hA5A5_0001);
    tick();
    check("t2_req2", bus.tx_req, 1);
    check("t2_data2", bus.tx_data, 32'h5A5A_0002);
    bus.in_vld = 1'b0;
    far_handshake(1, 1, seen);
    check("t2_seen2", seen, 32'h5A5A_0002);

    // Back-to-back words 1..8, then a randomized stream
    run_stream(8, 1'b0, 1'b0, 0);
    run_stream(24, 1'b1, 1'b1, 3);

    // Timeout with no ack
    bus.in_vld  = 1'b1;
    bus.in_data = 32'hC0DE_0004;
    tick();
    check("t4_req", bus.tx_req, 1);
    bus.in_vld = 1'b0;
    ticks(15);
    check("t4_no_err_yet", bus.err_timeout, 0);
    tick();
    check("t4_err", bus.err_timeout, 1);
    check("t4_req_stays", bus.tx_req, 1);
    ticks(3);
    check("t4_sticky", bus.err_timeout, 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("t4_cleared", bus.err_timeout, 0);
    far_handshake(0, 0, seen);
    check("t4_late_word", seen, 32'hC0DE_0004);
    check("t4_err_after", bus.err_timeout, 0);

    // Spurious ack while idle
    bus.ack_async = 1'b1;
    ticks(2);
    check("t5_rdy_low", bus.in_rdy, 0);
    check("t5_spur_not_yet", bus.err_spur, 0);
    tick();
    check("t5_spur", bus.err_spur, 1);
    bus.in_vld  = 1'b1;
    bus.in_data = 32'h0BAD_0005;
    ticks(3);
    check("t5_no_xfer", bus.tx_req, 0);
    check("t5_not_busy", bus.busy, 0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("t5_set_wins", bus.err_spur, 1);
    bus.ack_async = 1'b0;
    ticks(2);
    check("t5_rdy_back", bus.in_rdy, 1);
    check("t5_req_low", bus.tx_req, 0);
    tick();
    check("t5_req", bus.tx_req, 1);
    check("t5_data", bus.tx_data, 32'h0BAD_0005);
    bus.in_vld = 1'b0;
    far_handshake(2, 2, seen);
    check("t5_seen", seen, 32'h0BAD_0005);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("t5_spur_clr", bus.err_spur, 0);

    // Asynchronous reset in the middle of a request
    bus.in_vld  = 1'b1;
    bus.in_data = 32'h7777_0006;
    tick();
    bus.in_vld = 1'b0;
    check("t6_req", bus.tx_req, 1);
    ticks(2);
    #3;
    arst_l = 1'b0;
    #1;
    check("t6_rst_req", bus.tx_req, 0);
    check("t6_rst_data", bus.tx_data, 0);
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_rdy", bus.in_rdy, 1);
    check("t6_rst_errs", {bus.err_timeout, bus.err_spur}, 0);
    tick();
    arst_l = 1'b1;
    tick();
    check("t6_post_req", bus.tx_req, 0);
    bus.in_vld  = 1'b1;
    bus.in_data = 32'h1234_5678;
    tick();
    bus.in_vld = 1'b0;
    check("t6_fresh_req", bus.tx_req, 1);
    check("t6_fresh_data", bus.tx_data, 32'h1234_5678);
    far_handshake(1, 0, seen);
    check("t6_fresh_seen", seen, 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
